// File: rtl/multiplicador_punto_fijo_seq.sv
// Serial shift-add signed fixed-point multiplier with symmetric saturation.
// One multiplier bit per clock; start/done handshake, Y/ovf held until the next result.
module multiplicador_punto_fijo_seq #(
    parameter int Width     = 25,
    parameter int Signo     = 1,
    parameter int Magnitud  = 8,
    parameter int Presicion = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] Y,
    output logic             ovf
);

    localparam int W2 = 2 * Width;
    localparam int MW = W2 - Presicion;
    localparam int CW = $clog2(Width + 1);

    localparam logic [MW-1:0]    MAXM = {{(MW-Width+1){1'b0}}, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] MAXP = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] MAXN = {1'b1, {(Width-2){1'b0}}, 1'b1};

    if (Signo + Magnitud + Presicion != Width) begin : g_bad_cfg
        $error("Width must equal Signo+Magnitud+Presicion");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [Width-1:0] a_mag, b_mag;
    logic             sign;
    logic [W2-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [MW-1:0]    mag;
    logic [Width-1:0] y_nx;
    logic             ovf_nx;
    logic             unused_frac;

    // Most-negative code maps to 2^(Width-1), which still fits Width unsigned bits.
    function automatic logic [Width-1:0] magn(input logic [Width-1:0] v);
        return v[Width-1] ? (~v + 1'b1) : v;
    endfunction

    assign last = (cnt == CW'(Width));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Truncate the magnitude first, then re-apply sign: rounds toward zero both ways.
    assign mag         = acc[W2-1:Presicion];
    assign unused_frac = ^acc[Presicion-1:0];

    always_comb begin
        y_nx   = '0;
        ovf_nx = 1'b0;
        if (mag > MAXM) begin
            y_nx   = sign ? MAXN : MAXP;
            ovf_nx = 1'b1;
        end else begin
            y_nx = sign ? (~mag[Width-1:0] + 1'b1) : mag[Width-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag <= '0;
            b_mag <= '0;
            sign  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            Y     <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_mag <= magn(A);
                    b_mag <= magn(B);
                    sign  <= A[Width-1] ^ B[Width-1];
                    acc   <= '0;
                    cnt   <= '0;
                end
                CALC: if (!last) begin
                    if (b_mag[cnt]) acc <= acc + (W2'(a_mag) << cnt);
                    cnt <= cnt + 1'b1;
                end else begin
                    Y   <= y_nx;
                    ovf <= ovf_nx;
                end
                default: ;
            endcase
        end
    end

endmodule
